// File: rtl/sram_2p_arb_ctrl.sv
// Two-port SRAM controller: clears the array after reset, then arbitrates two
// write requesters round-robin onto the SRAM write port and forwards a single
// read requester to the SRAM read port with a one-cycle response.
// Optional feature macro: SRAM_ARB_BYPASS_EN -- when defined, a same-address
// write and read in one cycle return the newly written data instead of the
// old SRAM contents.
module sram_2p_arb_ctrl #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic             clock,
  input  logic             reset_n,
  // write requester 0
  input  logic             w0_valid,
  output logic             w0_ready,
  input  logic [AW-1:0]    w0_addr,
  input  logic [WIDTH-1:0] w0_data,
  // write requester 1
  input  logic             w1_valid,
  output logic             w1_ready,
  input  logic [AW-1:0]    w1_addr,
  input  logic [WIDTH-1:0] w1_data,
  // read request and response
  input  logic             r_valid,
  output logic             r_ready,
  input  logic [AW-1:0]    r_addr,
  output logic             rresp_valid,
  output logic [WIDTH-1:0] rresp_data,
  // status
  output logic             init_done,
  // SRAM write port
  output logic             sram_web,
  output logic [AW-1:0]    sram_aa,
  output logic [WIDTH-1:0] sram_d,
  // SRAM read port
  output logic             sram_reb,
  output logic [AW-1:0]    sram_ab,
  input  logic [WIDTH-1:0] sram_q
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
  logic            rr_q, rr_d;          // 0: w0 wins a tie, 1: w1 wins a tie
  logic            rresp_valid_q;

  logic             w_fire;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;
  logic             r_fire;

  // State, clear counter, arbitration pointer and response-valid registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StInit;
      init_cnt_q    <= '0;
      rr_q          <= 1'b0;
      rresp_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      rr_q          <= rr_d;
      rresp_valid_q <= r_fire;
    end
  end

  // Next-state: walk the clear counter through every address, then run
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_d       = rr_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == AW'(DEPTH - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Pointer moves to whichever requester lost (or was not served)
        if (w0_ready) begin
          rr_d = 1'b1;
        end else if (w1_ready) begin
          rr_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs: clear writes in INIT, arbitrated writes and reads in RUN
  always_comb begin
    w0_ready  = 1'b0;
    w1_ready  = 1'b0;
    r_ready   = 1'b0;
    init_done = 1'b0;
    w_fire    = 1'b0;
    w_addr    = w0_addr;
    w_data    = w0_data;
    r_fire    = 1'b0;
    sram_web  = 1'b1;
    sram_aa   = init_cnt_q;
    sram_d    = '0;
    sram_reb  = 1'b1;
    sram_ab   = r_addr;
    unique case (state_q)
      StInit: begin
        // Reset parks the FSM in INIT; keep the array untouched while held
        sram_web = ~reset_n;
      end
      StRun: begin
        init_done = 1'b1;
        r_ready   = 1'b1;
        r_fire    = r_valid;
        sram_reb  = ~r_valid;
        w0_ready  = w0_valid & (~w1_valid | ~rr_q);
        w1_ready  = w1_valid & (~w0_valid | rr_q);
        w_fire    = w0_ready | w1_ready;
        if (w1_ready) begin
          w_addr = w1_addr;
          w_data = w1_data;
        end
        sram_web = ~w_fire;
        sram_aa  = w_addr;
        sram_d   = w_data;
      end
      default: ;
    endcase
  end

  assign rresp_valid = rresp_valid_q;

`ifdef SRAM_ARB_BYPASS_EN
  logic             byp_hit_q;
  logic [WIDTH-1:0] byp_data_q;

  // Capture a same-cycle write to the address being read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q <= r_fire & w_fire & (w_addr == r_addr);
      if (w_fire) begin
        byp_data_q <= w_data;
      end
    end
  end

  assign rresp_data = !rresp_valid_q ? '0 : (byp_hit_q ? byp_data_q : sram_q);
`else
  // Mask the SRAM's undefined output when no read was issued
  assign rresp_data = rresp_valid_q ? sram_q : '0;
`endif

endmodule

// File: doc/sram_2p_arb_ctrl.md
SRAM_2P_ARB_CTRL -- requirements
Module: sram_2p_arb_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 2, entry data width.
REQ-002 SHALL have parameter DEPTH, default 512, number of entries.
REQ-003 SHALL have parameter AW, default 9, address width; DEPTH = 2**AW.
REQ-004 SHALL have port clock, input, 1: single clock; the SRAM CLKW and CLKR are both tied to it outside this block.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have ports w0_valid (input, 1), w0_ready (output, 1), w0_addr (input, AW) and w0_data (input, WIDTH): write requester 0.
REQ-007 SHALL have ports w1_valid (input, 1), w1_ready (output, 1), w1_addr (input, AW) and w1_data (input, WIDTH): write requester 1.
REQ-008 SHALL have ports r_valid (input, 1), r_ready (output, 1) and r_addr (input, AW): read request.
REQ-009 SHALL have ports rresp_valid (output, 1) and rresp_data (output, WIDTH): read response.
REQ-010 SHALL have port init_done, output, 1: high once the clear sequence is complete.
REQ-011 SHALL have ports sram_web (output, 1, active-low), sram_aa (output, AW) and sram_d (output, WIDTH): SRAM write port.
REQ-012 SHALL have ports sram_reb (output, 1, active-low), sram_ab (output, AW) and sram_q (input, WIDTH): SRAM read port; Q is registered by the SRAM on the clock edge.

Function
REQ-013 SHALL implement two states: INIT and RUN.
REQ-014 In INIT, the block SHALL write 0 to address init_cnt every cycle, with sram_web=0 and sram_d=0; init_cnt counts 0..DEPTH-1.
REQ-015 In INIT, w0_ready, w1_ready and r_ready SHALL be 0, and sram_reb SHALL be 1.
REQ-016 After the write to address DEPTH-1, the block SHALL enter RUN on the next edge with init_done=1; INIT SHALL last exactly DEPTH cycles.
REQ-017 In RUN, the block SHALL accept at most one write per cycle.
REQ-018 With a single valid write requester, that requester SHALL be granted.
REQ-019 With both write requesters valid, the requester selected by round-robin pointer rr SHALL be granted.
REQ-020 rr SHALL point at the non-granted requester after any grant.
REQ-021 wN_ready SHALL be 1 only for the granted requester, combinationally from the valids; a write fires on valid&ready.
REQ-022 On a write fire, the block SHALL drive sram_web=0, sram_aa=addr and sram_d=data in the same cycle; otherwise sram_web=1.
REQ-023 In RUN, r_ready SHALL be 1 every cycle.
REQ-024 On a read fire, the block SHALL drive sram_reb=0 and sram_ab=r_addr; otherwise sram_reb=1.
REQ-025 rresp_valid SHALL be 1 exactly one cycle after a read fire (latency 1), with rresp_data=sram_q; back-to-back reads SHALL give back-to-back responses.
REQ-026 When rresp_valid=0, rresp_data SHALL be 0, so the SRAM's random output on an unselected read is masked.
REQ-027 A read and a write to different addresses in the same cycle SHALL both proceed.
REQ-028 A read and a write to the same address in the same cycle SHALL be handled per REQ-033/REQ-034.

Reset
REQ-029 On reset_n=0, the block SHALL asynchronously set: state=INIT, init_cnt=0, rr=0 (w0 first), init_done=0, rresp_valid=0.
REQ-030 While reset_n=0, the block SHALL drive sram_web=1 and sram_reb=1, and all ready outputs SHALL be 0.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL abort any in-flight response, and the clear SHALL restart at address 0 after release.
REQ-032 Reset release SHALL be synchronized externally; the block SHALL begin INIT on the first edge after release.

Configuration
REQ-033 With macro SRAM_ARB_BYPASS_EN defined, a same-address same-cycle write and read SHALL return the written data on rresp_data the next cycle, via a registered bypass flag and data.
REQ-034 With SRAM_ARB_BYPASS_EN undefined, the same collision SHALL return the old SRAM contents (sram_q), and no bypass registers SHALL exist.

Verification
REQ-035 Release reset, then read address 0 and address 511 right after init_done -> init_done rises exactly 512 cycles after release; both responses are 0.
REQ-036 w0 and w1 both valid for 4 cycles (addresses 1..4 and 5..8) -> grants alternate w0, w1, w0, w1; sram_aa = 1, 5, 2, 6.
REQ-037 Write 0x3 to address 10, then read address 10 next cycle -> rresp_valid one cycle after the read fire; rresp_data=0x3.
REQ-038 Write 0x2 to address 20 and read address 20 in the same cycle (address 20 previously 0x1) -> rresp_data=0x2 with SRAM_ARB_BYPASS_EN; 0x1 without it.
REQ-039 Assert reset_n=0 mid-RUN one cycle after a read fire -> rresp_valid=0 immediately; INIT restarts; init_done=0 until 512 cycles after release.
REQ-040 No read fires for 3 cycles -> rresp_valid=0 and rresp_data=0 throughout, and sram_reb=1.
